// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the divider_w iterative divider.
//   div_state_t   : FSM state encoding (IDLE, PREP, CALC, FIXUP)
//   iter_count()  : number of CALC iterations for a given width/mode
//   quot_in_range(): signed quotient range check for an N-bit result
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PREP  = 2'd1,
    CALC  = 2'd2,
    FIXUP = 2'd3
  } div_state_t;

  // Wide mode produces WIDTH quotient bits, narrow mode WIDTH/2.
  function automatic int unsigned iter_count(input int unsigned width,
                                             input int unsigned bpc,
                                             input logic        wide);
    return (wide ? width : width / 2) / bpc;
  endfunction

  // A positive quotient may reach 2^(n-1)-1; a negative one may reach 2^(n-1)
  // in magnitude.  mag is the unsigned quotient magnitude, zero-extended.
  function automatic logic quot_in_range(input int unsigned n,
                                         input logic        neg,
                                         input logic [63:0] mag);
    logic [63:0] lim;
    lim = 64'd1 << (n - 1);
    if (!neg) lim = lim - 64'd1;
    return mag <= lim;
  endfunction

endpackage

// File: rtl/divider_w_if.sv
// divider_w_if: operand/result bundle between the microcode sequencer and
// the divider.
//   start, wide, is_signed, num[2W], denom[W] : request side (master drives)
//   busy, done, valid, dbz, ovf, quot[W], rem[W] : status/result (slave drives)
interface divider_w_if #(
  parameter int WIDTH = 16
);
  logic                   start;
  logic                   wide;
  logic                   is_signed;
  logic [2*WIDTH-1:0]     num;
  logic [WIDTH-1:0]       denom;
  logic                   busy;
  logic                   done;
  logic                   valid;
  logic                   dbz;
  logic                   ovf;
  logic [WIDTH-1:0]       quot;
  logic [WIDTH-1:0]       rem;

  modport master (
    output start, wide, is_signed, num, denom,
    input  busy, done, valid, dbz, ovf, quot, rem
  );

  modport slave (
    input  start, wide, is_signed, num, denom,
    output busy, done, valid, dbz, ovf, quot, rem
  );
endinterface

// File: rtl/div_step.sv
// div_step: combinational BITS_PER_CYCLE restoring shift-subtract steps over
// the {remainder, dividend} register pair.  Quotient bits shift in at the
// LSB of the dividend register as dividend bits shift out of its MSB.
//   rem_in/low_in  : current partial remainder / dividend-quotient register
//   den            : divisor magnitude
//   rem_out/low_out: values after BITS_PER_CYCLE steps
module div_step #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] low_in,
  input  logic [WIDTH-1:0] den,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] low_out
);

  logic [WIDTH:0] trial;

  always_comb begin
    rem_out = rem_in;
    low_out = low_in;
    trial   = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      // Partial remainder stays below den, so one extra bit holds the shift.
      trial = {rem_out, low_out[WIDTH-1]};
      if (trial >= {1'b0, den}) begin
        trial   = trial - {1'b0, den};
        rem_out = trial[WIDTH-1:0];
        low_out = {low_out[WIDTH-2:0], 1'b1};
      end else begin
        rem_out = trial[WIDTH-1:0];
        low_out = {low_out[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/divider_w.sv
// divider_w: iterative signed/unsigned integer divider, 2W/W (wide) or
// W/(W/2) (narrow), BITS_PER_CYCLE quotient bits per enabled clock.
// Detects divide-by-zero and quotient overflow.
//   clk, reset (async, active-high), ce (clock enable)
//   bus : divider_w_if.slave (start/wide/is_signed/num/denom in;
//         busy/done/valid/dbz/ovf/quot/rem out)
// Build option: define DIV_EARLY_OUT_EN to skip CALC when the dividend
// magnitude is already below the divisor magnitude (same results, lower
// latency).
//
// state | meaning
// IDLE  | waiting for start; result outputs held
// PREP  | divide-by-zero / overflow screening, counter load
// CALC  | shift-subtract iterations
// FIXUP | sign correction, signed range check, publish result
module divider_w
  import div_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  divider_w_if.slave  bus
);

  localparam int          HW          = WIDTH / 2;
  localparam int unsigned ITER_WIDE   = iter_count(WIDTH, BITS_PER_CYCLE, 1'b1);
  localparam int unsigned ITER_NARROW = iter_count(WIDTH, BITS_PER_CYCLE, 1'b0);
  localparam int          CNT_W       = $clog2(ITER_WIDE + 1);

  div_state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0] rem_q, low_q, den_q;
  logic             wide_q, sgn_q, num_neg_q, den_neg_q;
  logic             done_q, valid_q, dbz_q, ovf_q;
  logic [WIDTH-1:0] quot_q, rem_res_q;

  // Operand magnitudes taken straight from the request
  logic               num_neg, den_neg;
  logic [2*WIDTH-1:0] num_mag_w;
  logic [WIDTH-1:0]   num_mag_n;
  logic [WIDTH-1:0]   den_mag;

  always_comb begin
    num_neg   = bus.wide ? bus.num[2*WIDTH-1] : bus.num[WIDTH-1];
    den_neg   = bus.wide ? bus.denom[WIDTH-1] : bus.denom[HW-1];
    num_mag_w = (bus.is_signed && num_neg) ? -bus.num : bus.num;
    num_mag_n = (bus.is_signed && num_neg) ? -bus.num[WIDTH-1:0] : bus.num[WIDTH-1:0];
    if (bus.wide)
      den_mag = (bus.is_signed && den_neg) ? -bus.denom : bus.denom;
    else
      den_mag = {{HW{1'b0}},
                 (bus.is_signed && den_neg) ? -bus.denom[HW-1:0] : bus.denom[HW-1:0]};
  end

  // PREP screening.  rem_q holds the upper half of the dividend magnitude,
  // so the overflow test is a single compare in both modes.
  logic den_zero, prep_ovf;
  assign den_zero = (den_q == '0);
  assign prep_ovf = (rem_q >= den_q);

`ifdef DIV_EARLY_OUT_EN
  logic [WIDTH-1:0] dividend_low;
  logic             early_lt;
  assign dividend_low = wide_q ? low_q : {{HW{1'b0}}, low_q[WIDTH-1:HW]};
  assign early_lt     = (rem_q == '0) && (dividend_low < den_q);
`endif

  // Iteration datapath
  logic [WIDTH-1:0] step_rem, step_low;

  div_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .rem_in  (rem_q),
    .low_in  (low_q),
    .den     (den_q),
    .rem_out (step_rem),
    .low_out (step_low)
  );

  assign cnt_nxt = cnt_q - CNT_W'(1);

  // Sign fixup and range check
  logic             neg_quot, neg_rem, range_ok;
  logic [WIDTH-1:0] res_mask, quot_fix, rem_fix;

  assign neg_quot = sgn_q & (num_neg_q ^ den_neg_q);
  assign neg_rem  = sgn_q & num_neg_q;
  assign res_mask = wide_q ? {WIDTH{1'b1}} : {{HW{1'b0}}, {HW{1'b1}}};
  assign quot_fix = (neg_quot ? -low_q : low_q) & res_mask;
  assign rem_fix  = (neg_rem  ? -rem_q : rem_q) & res_mask;
  assign range_ok = !sgn_q ||
                    quot_in_range(wide_q ? 32'(WIDTH) : 32'(HW), neg_quot, 64'(low_q));

  // FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ce) begin
      case (state_q)
        IDLE:  if (bus.start) state_d = PREP;
        PREP: begin
          if (den_zero || prep_ovf) state_d = IDLE;
`ifdef DIV_EARLY_OUT_EN
          else if (early_lt)        state_d = FIXUP;
`endif
          else                      state_d = CALC;
        end
        CALC:  if (cnt_nxt == '0) state_d = FIXUP;
        FIXUP: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      low_q     <= '0;
      den_q     <= '0;
      wide_q    <= 1'b0;
      sgn_q     <= 1'b0;
      num_neg_q <= 1'b0;
      den_neg_q <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
      quot_q    <= '0;
      rem_res_q <= '0;
    end else if (ce) begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            wide_q    <= bus.wide;
            sgn_q     <= bus.is_signed;
            num_neg_q <= num_neg;
            den_neg_q <= den_neg;
            den_q     <= den_mag;
            if (bus.wide) begin
              rem_q <= num_mag_w[2*WIDTH-1:WIDTH];
              low_q <= num_mag_w[WIDTH-1:0];
            end else begin
              // Narrow dividend sits in the top half of low_q so the same
              // MSB-first stepping applies; quotient bits fill the bottom.
              rem_q <= {{HW{1'b0}}, num_mag_n[WIDTH-1:HW]};
              low_q <= {num_mag_n[HW-1:0], {HW{1'b0}}};
            end
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
            quot_q    <= '0;
            rem_res_q <= '0;
          end
        end
        PREP: begin
          if (den_zero) begin
            dbz_q  <= 1'b1;
            done_q <= 1'b1;
          end else if (prep_ovf) begin
            ovf_q  <= 1'b1;
            done_q <= 1'b1;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (early_lt) begin
            rem_q <= dividend_low;
            low_q <= '0;
          end
`endif
          else begin
            cnt_q <= wide_q ? CNT_W'(ITER_WIDE) : CNT_W'(ITER_NARROW);
          end
        end
        CALC: begin
          rem_q <= step_rem;
          low_q <= step_low;
          cnt_q <= cnt_nxt;
        end
        FIXUP: begin
          done_q <= 1'b1;
          if (range_ok) begin
            valid_q   <= 1'b1;
            quot_q    <= quot_fix;
            rem_res_q <= rem_fix;
          end else begin
            ovf_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.valid = valid_q;
  assign bus.dbz   = dbz_q;
  assign bus.ovf   = ovf_q;
  assign bus.quot  = quot_q;
  assign bus.rem   = rem_res_q;

endmodule

// File: tb/tb_divider_w.sv
// tb_divider_w: directed-vector bench for divider_w (WIDTH=16,
// BITS_PER_CYCLE=1).  Counts enabled edges from the accepting edge to the
// rising edge of done and checks latency plus all result outputs.
// Honours DIV_EARLY_OUT_EN for the expected early-out latency.
module tb_divider_w;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic ce    = 1'b0;

  always #5 clk = ~clk;

  divider_w_if #(.WIDTH(16)) bus ();

  divider_w #(
    .WIDTH          (16),
    .BITS_PER_CYCLE (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_E = 2;
`else
  localparam int EARLY_E = 18;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic w, input logic s,
                       input logic [31:0] n, input logic [15:0] d,
                       input bit tog, input bit poke, input int exp_e,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic ev, input logic edbz, input logic eovf);
    int edges;
    int cyc;
    @(negedge clk);
    ce            = 1'b1;
    bus.wide      = w;
    bus.is_signed = s;
    bus.num       = n;
    bus.denom     = d;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    chk({tag, "_clr"},  64'(bus.done), 64'd0);
    edges = 0;
    cyc   = 0;
    while (!bus.done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      ce = tog ? ~ce : 1'b1;
      if (poke && edges == 3) begin
        bus.start = 1'b1;
        bus.denom = 16'h0000;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      if (ce) edges++;
      #1;
    end
    bus.start = 1'b0;
    ce        = 1'b1;
    chk({tag, "_lat"},   64'(edges),     64'(exp_e));
    chk({tag, "_quot"},  64'(bus.quot),  64'(eq));
    chk({tag, "_rem"},   64'(bus.rem),   64'(er));
    chk({tag, "_valid"}, 64'(bus.valid), 64'(ev));
    chk({tag, "_dbz"},   64'(bus.dbz),   64'(edbz));
    chk({tag, "_ovf"},   64'(bus.ovf),   64'(eovf));
    chk({tag, "_idle"},  64'(bus.busy),  64'd0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.wide      = 1'b0;
    bus.is_signed = 1'b0;
    bus.num       = '0;
    bus.denom     = '0;
    repeat (2) @(negedge clk);
    chk("rst_done",  64'(bus.done),  64'd0);
    chk("rst_busy",  64'(bus.busy),  64'd0);
    chk("rst_valid", 64'(bus.valid), 64'd0);
    chk("rst_flags", 64'({bus.dbz, bus.ovf}), 64'd0);
    chk("rst_quot",  64'(bus.quot),  64'd0);
    chk("rst_rem",   64'(bus.rem),   64'd0);
    reset = 1'b0;

    //          tag         w  s  num           denom    tog poke lat  quot     rem      v  z  o
    do_op("u_wide",     1, 0, 32'h00010005, 16'h0003, 0, 0, 18, 16'h5557, 16'h0000, 1, 0, 0);
    do_op("s_wide",     1, 1, 32'hFFFFFFF9, 16'h0002, 0, 0, 18, 16'hFFFD, 16'hFFFF, 1, 0, 0);
    do_op("dbz",        1, 0, 32'h00001234, 16'h0000, 0, 0, 1,  16'h0000, 16'h0000, 0, 1, 0);
    do_op("u_ovf",      1, 0, 32'h00030000, 16'h0002, 0, 0, 1,  16'h0000, 16'h0000, 0, 0, 1);
    do_op("s_ovf",      1, 1, 32'hFFFF8000, 16'hFFFF, 0, 0, 18, 16'h0000, 16'h0000, 0, 0, 1);
    do_op("s_min",      1, 1, 32'hFFFF8000, 16'h0001, 0, 0, 18, 16'h8000, 16'h0000, 1, 0, 0);
    do_op("n_u",        0, 0, 32'h00000064, 16'h0007, 0, 0, 10, 16'h000E, 16'h0002, 1, 0, 0);
    do_op("n_ce",       0, 0, 32'h00000064, 16'h0007, 1, 0, 10, 16'h000E, 16'h0002, 1, 0, 0);
    do_op("n_s",        0, 1, 32'h0000FFF9, 16'h0002, 0, 0, 10, 16'h00FD, 16'h00FF, 1, 0, 0);
    do_op("n_dbz",      0, 0, 32'h00000064, 16'h0100, 0, 0, 1,  16'h0000, 16'h0000, 0, 1, 0);
    do_op("busy_start", 0, 0, 32'h00000064, 16'h0007, 0, 1, 10, 16'h000E, 16'h0002, 1, 0, 0);

    // Reset in the middle of an operation
    @(negedge clk);
    ce            = 1'b1;
    bus.wide      = 1'b1;
    bus.is_signed = 1'b0;
    bus.num       = 32'h00010005;
    bus.denom     = 16'h0003;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_quot", 64'(bus.quot), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_nodone", 64'(bus.done), 64'd0);

    do_op("post_rst",   1, 1, 32'hFFFFFFF9, 16'h0002, 0, 0, 18, 16'hFFFD, 16'hFFFF, 1, 0, 0);
    do_op("early",      1, 0, 32'h00000005, 16'h0009, 0, 0, EARLY_E, 16'h0000, 16'h0005, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
